// File: rtl/i2s_pkg.sv
// Shared defaults, FSM state type and frame-width helper for the I2S playback transmitter.
package i2s_pkg;

  localparam int DATA_W_DEF    = 24;
  localparam int SLOT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    SYNC,
    DLY,
    SHIFT,
    PAD
  } tx_state_t;

  // A FIFO entry carries one stereo pair: left in the upper half, right in the lower half.
  function automatic int frame_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous first-word-fall-through FIFO holding stereo frame pairs.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW + 1)'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_playback_tx.sv
// I2S playback serializer clocked by sysclk, following externally generated bclk/lrclk.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (no one-bclk MSB delay).
//
//   state | meaning
//   SYNC  | idle/disabled, waiting for a left-slot start
//   DLY   | one-bclk I2S delay before the MSB
//   SHIFT | driving sample bits MSB first
//   PAD   | slot bits after the sample, driven 0
module i2s_playback_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SLOT_BITS  = SLOT_BITS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic [DATA_W-1:0]             in_left,
  input  logic [DATA_W-1:0]             in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          pbdata,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FW    = frame_w(DATA_W);
  localparam int CNT_W = $clog2(SLOT_BITS + 1);

  logic bclk_m, bclk_s, bclk_d;
  logic lrc_m, lrc_s, lrc_prev;
  logic bclk_fall, chg, left_start, right_start;
  logic fifo_full, fifo_empty, push, pop;
  logic [FW-1:0]     fifo_rd;
  logic [DATA_W-1:0] left_word, right_word, start_word;
  logic [DATA_W-1:0] shift_reg, right_hold;
  logic [CNT_W-1:0]  bit_cnt;
  tx_state_t         state;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_m   <= 1'b0;
      bclk_s   <= 1'b0;
      bclk_d   <= 1'b0;
      lrc_m    <= 1'b0;
      lrc_s    <= 1'b0;
      lrc_prev <= 1'b0;
    end else begin
      bclk_m <= bclk;
      bclk_s <= bclk_m;
      bclk_d <= bclk_s;
      lrc_m  <= lrclk;
      lrc_s  <= lrc_m;
      if (bclk_fall) lrc_prev <= lrc_s;
    end
  end

  assign bclk_fall   = bclk_d & ~bclk_s;
  assign chg         = bclk_fall & (lrc_s ^ lrc_prev);
  assign left_start  = enable & chg & ~lrc_s;
  assign right_start = enable & chg & lrc_s & (state != SYNC);

  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full;
  assign pop      = left_start & ~fifo_empty;

  i2s_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({in_left, in_right}),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An empty FIFO at left start sends a silent frame rather than stale data.
  assign left_word  = fifo_empty ? '0 : fifo_rd[FW-1:DATA_W];
  assign right_word = fifo_empty ? '0 : fifo_rd[DATA_W-1:0];
  assign start_word = left_start ? left_word : right_hold;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      pbdata      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      shift_reg   <= '0;
      right_hold  <= '0;
      bit_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (!enable) begin
        state  <= SYNC;
        pbdata <= 1'b0;
      end else if (left_start || right_start) begin
        if (left_start) begin
          right_hold  <= right_word;
          frame_start <= ~fifo_empty;
          underrun    <= fifo_empty;
        end
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        pbdata    <= start_word[DATA_W-1];
        shift_reg <= {start_word[DATA_W-2:0], 1'b0};
        bit_cnt   <= CNT_W'(DATA_W - 1);
        state     <= SHIFT;
`else
        pbdata    <= 1'b0;
        shift_reg <= start_word;
        bit_cnt   <= CNT_W'(DATA_W);
        state     <= DLY;
`endif
      end else if (bclk_fall) begin
        case (state)
          DLY, SHIFT: begin
            pbdata    <= shift_reg[DATA_W-1];
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - CNT_W'(1);
            state     <= (bit_cnt == CNT_W'(1)) ? PAD : SHIFT;
          end
          default: pbdata <= 1'b0;
        endcase
      end
    end
  end

endmodule
